q_argmax_scan: RTL and testbench
================================

// Module: q_argmax_scan
// PURPOSE
//  Sequential greedy-action finder for the Dyna-Q datapath. On start, reads the
//  NUM_ACTIONS Q-values of one state from the Q-table RAM (1-cycle read latency)
//  and reports the maximum Q-value and its action index with a one-cycle done pulse.
//  Sits directly upstream of the enable-gated result registers: done drives their
//  enable, and max_q/best_action drive their write data.
// PARAMETERS
//  DATA_LENGTH   32  width of a signed two's-complement Q-value
//  NUM_ACTIONS   4   actions per state, >=2
//  ACTION_WIDTH  2   bits of action index, >= clog2(NUM_ACTIONS)
//  STATE_WIDTH   8   bits of state index
// PORTS
//  clk          in   1                          single clock, rising edge
//  reset        in   1                          synchronous, active-high
//  start        in   1                          request a scan; sampled only in IDLE
//  state_in     in   STATE_WIDTH                state to scan; captured when start is accepted
//  busy         out  1                          high whenever FSM is not in IDLE
//  rd_en        out  1                          Q-table read strobe
//  rd_addr      out  STATE_WIDTH+ACTION_WIDTH   {state, action}
//  rd_data      in   DATA_LENGTH                signed Q-value, valid 1 cycle after rd_en
//  max_q        out  DATA_LENGTH                signed maximum found
//  best_action  out  ACTION_WIDTH               index of max_q
//  done         out  1                          one-cycle pulse: results valid
// BEHAVIOUR
//  - Reset (sync, active-high): FSM=IDLE; busy, rd_en, done = 0; rd_addr, max_q,
//    best_action = 0; action counter = 0. Reset mid-scan aborts with no done pulse.
//  - FSM states: IDLE -> SCAN -> DRAIN -> DONE -> IDLE.
//    IDLE:  start=1 at edge E0 -> latch state_in, counter=0, go to SCAN.
//    SCAN:  N=NUM_ACTIONS cycles; cycle k (k=0..N-1): rd_en=1, rd_addr={state,k}.
//           After the issue with k=N-1, go to DRAIN.
//    DRAIN: rd_en=0; last rd_data captured; go to DONE.
//    DONE:  done=1 for exactly one cycle; go to IDLE.
//  - Latency: start accepted at E0 -> done high in cycle N+2 (N=4: 6 cycles).
//  - Comparison: data returned for action 0 unconditionally loads the running
//    max/index. Later data replaces them only if strictly greater (signed). Ties
//    keep the lowest action index.
//  - max_q/best_action: registered; update only when done rises; hold until the
//    next done or reset. Internal running values are not visible mid-scan.
//  - start while busy (SCAN/DRAIN/DONE): ignored, not queued. state_in is only
//    sampled at acceptance, so changes mid-scan have no effect.
//  - Back-to-back: start asserted in the cycle after done is accepted (FSM is in IDLE).
//  - rd_addr holds its last value while rd_en=0. Action counter never exceeds N-1;
//    no wrap into a neighbouring state's addresses.
//  - Extreme values: the most negative DATA_LENGTH value is a legal Q-value. If all
//    Q-values equal it -> best_action=0.
// STRUCTURE
//  - Shared package: FSM state encodings (IDLE/SCAN/DRAIN/DONE), Q-value type of
//    DATA_LENGTH signed, helper function to form {state,action} address.
//  - One sub-module: q_max_accum, holding the running max/index registers.
//    Inputs: valid, first, data, index. Does a signed strict-greater compare.
//  - Top level: FSM, action counter, read-address generation, rd_en->valid delay
//    flop, output registers gated by done.
// TESTING
//  1. Q[s=5] = {10,-3,42,7}, start -> rd_addr 0x14..0x17 on 4 consecutive cycles;
//     done at cycle 6; max_q=42, best_action=2.
//  2. Ties: Q = {9,9,9,9} -> best_action=0, max_q=9. Q = {1,9,9,3} -> best_action=1.
//  3. All negative: Q = {-5,-2,-8,0x80000000} -> max_q=-2, best_action=1.
//  4. Pulse start repeatedly while busy, and change state_in mid-scan -> exactly one
//     done, using the state captured at acceptance.
//  5. Assert reset in SCAN cycle 2 -> next cycle busy=0, rd_en=0, no done pulse,
//     outputs=0; a following start runs a full, correct scan.
//  6. Back-to-back: start in the cycle after done -> second done 6 cycles later,
//     outputs update only at each done.

Source files
------------

// File: rtl/q_argmax_scan_pkg.sv
// Shared definitions for the Q-table greedy-action scanner.
//   - scan_state_e : FSM encodings (IDLE/SCAN/DRAIN/DONE)
//   - q_val_t      : signed Q-value of the default DATA_LENGTH
//   - mk_rd_addr   : forms the {state, action} Q-table address
package q_argmax_scan_pkg;

  localparam int DATA_LENGTH  = 32;
  localparam int NUM_ACTIONS  = 4;
  localparam int ACTION_WIDTH = 2;
  localparam int STATE_WIDTH  = 8;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SCAN  = 2'd1,
    ST_DRAIN = 2'd2,
    ST_DONE  = 2'd3
  } scan_state_e;

  typedef logic signed [DATA_LENGTH-1:0] q_val_t;

  // Width-agnostic address former; callers truncate to their address width.
  function automatic logic [63:0] mk_rd_addr(input logic [31:0] st,
                                             input logic [31:0] act,
                                             input int          act_w);
    return ({32'b0, st} << act_w) | {32'b0, act};
  endfunction

endpackage

// File: rtl/q_argmax_scan_if.sv
// Bus bundle between the scanner, its requester and the Q-table RAM.
//   start/state_in        : scan request
//   busy/done             : status, done is a one-cycle result strobe
//   rd_en/rd_addr/rd_data : Q-table read port (1-cycle latency)
//   max_q/best_action     : registered scan result
// slave  = scanner side, master = requester/RAM side.
interface q_argmax_scan_if #(
  parameter int DATA_LENGTH  = 32,
  parameter int ACTION_WIDTH = 2,
  parameter int STATE_WIDTH  = 8
);
  logic                                 start;
  logic [STATE_WIDTH-1:0]               state_in;
  logic                                 busy;
  logic                                 rd_en;
  logic [STATE_WIDTH+ACTION_WIDTH-1:0]  rd_addr;
  logic signed [DATA_LENGTH-1:0]        rd_data;
  logic signed [DATA_LENGTH-1:0]        max_q;
  logic [ACTION_WIDTH-1:0]              best_action;
  logic                                 done;

  modport slave (
    input  start, state_in, rd_data,
    output busy, rd_en, rd_addr, max_q, best_action, done
  );

  modport master (
    output start, state_in, rd_data,
    input  busy, rd_en, rd_addr, max_q, best_action, done
  );
endinterface

// File: rtl/q_argmax_scan_max_accum.sv
// q_max_accum: running signed maximum and its index.
//   valid   : data/index carry a returned Q-value this cycle
//   first   : this is action 0, load unconditionally
//   data    : signed Q-value
//   index   : action index of data
//   max_nxt : running max including this cycle's data (combinational)
//   idx_nxt : index of max_nxt
// Strict greater-than keeps the lowest index on ties.
module q_max_accum #(
  parameter int DATA_LENGTH  = 32,
  parameter int ACTION_WIDTH = 2
) (
  input  logic                           clk,
  input  logic                           reset,
  input  logic                           valid,
  input  logic                           first,
  input  logic signed [DATA_LENGTH-1:0]  data,
  input  logic [ACTION_WIDTH-1:0]        index,
  output logic signed [DATA_LENGTH-1:0]  max_nxt,
  output logic [ACTION_WIDTH-1:0]        idx_nxt
);
  logic signed [DATA_LENGTH-1:0] run_max_q, run_max_d;
  logic [ACTION_WIDTH-1:0]       run_idx_q, run_idx_d;

  always_comb begin
    run_max_d = run_max_q;
    run_idx_d = run_idx_q;
    if (valid && (first || (data > run_max_q))) begin
      run_max_d = data;
      run_idx_d = index;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      run_max_q <= '0;
      run_idx_q <= '0;
    end else begin
      run_max_q <= run_max_d;
      run_idx_q <= run_idx_d;
    end
  end

  // The final data beat lands in the same cycle the result registers load,
  // so the top samples the next-state values.
  assign max_nxt = run_max_d;
  assign idx_nxt = run_idx_d;
endmodule

// File: rtl/q_argmax_scan.sv
// q_argmax_scan: sequential greedy-action finder.
//   clk, reset : single clock, synchronous active-high reset
//   bus        : q_argmax_scan_if.slave (start/state_in request, Q-table
//                read port, busy/done status, max_q/best_action result)
// Reads NUM_ACTIONS Q-values of one state, one per cycle, and reports the
// signed maximum with its lowest action index, strobing done for one cycle.
module q_argmax_scan
  import q_argmax_scan_pkg::*;
#(
  parameter int DATA_LENGTH  = q_argmax_scan_pkg::DATA_LENGTH,
  parameter int NUM_ACTIONS  = q_argmax_scan_pkg::NUM_ACTIONS,
  parameter int ACTION_WIDTH = q_argmax_scan_pkg::ACTION_WIDTH,
  parameter int STATE_WIDTH  = q_argmax_scan_pkg::STATE_WIDTH
) (
  input  logic          clk,
  input  logic          reset,
  q_argmax_scan_if.slave bus
);
  localparam int ADDR_WIDTH = STATE_WIDTH + ACTION_WIDTH;
  localparam logic [ACTION_WIDTH-1:0] LAST_ACT = ACTION_WIDTH'(NUM_ACTIONS - 1);

  scan_state_e                   st_q, st_d;
  logic [STATE_WIDTH-1:0]        state_q, state_d;
  logic [ACTION_WIDTH-1:0]       cnt_q, cnt_d;
  // rd_en delayed to line up with rd_data
  logic                          vld_q, vld_d;
  logic [ACTION_WIDTH-1:0]       vidx_q, vidx_d;
  logic signed [DATA_LENGTH-1:0] max_q_q, max_q_d;
  logic [ACTION_WIDTH-1:0]       best_q, best_d;

  logic signed [DATA_LENGTH-1:0] acc_max;
  logic [ACTION_WIDTH-1:0]       acc_idx;

  always_comb begin
    st_d    = st_q;
    state_d = state_q;
    cnt_d   = cnt_q;
    unique case (st_q)
      ST_IDLE: begin
        if (bus.start) begin
          state_d = bus.state_in;
          cnt_d   = '0;
          st_d    = ST_SCAN;
        end
      end
      ST_SCAN: begin
        // Counter parks on the last action so rd_addr never strays into
        // the neighbouring state's entries.
        if (cnt_q == LAST_ACT) st_d  = ST_DRAIN;
        else                   cnt_d = cnt_q + 1'b1;
      end
      ST_DRAIN: st_d = ST_DONE;
      ST_DONE:  st_d = ST_IDLE;
      default:  st_d = ST_IDLE;
    endcase
  end

  always_comb begin
    vld_d   = (st_q == ST_SCAN);
    vidx_d  = cnt_q;
    max_q_d = max_q_q;
    best_d  = best_q;
    // DRAIN -> DONE edge: result registers change exactly as done rises.
    if (st_q == ST_DRAIN) begin
      max_q_d = acc_max;
      best_d  = acc_idx;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      st_q    <= ST_IDLE;
      state_q <= '0;
      cnt_q   <= '0;
      vld_q   <= 1'b0;
      vidx_q  <= '0;
      max_q_q <= '0;
      best_q  <= '0;
    end else begin
      st_q    <= st_d;
      state_q <= state_d;
      cnt_q   <= cnt_d;
      vld_q   <= vld_d;
      vidx_q  <= vidx_d;
      max_q_q <= max_q_d;
      best_q  <= best_d;
    end
  end

  q_max_accum #(
    .DATA_LENGTH (DATA_LENGTH),
    .ACTION_WIDTH(ACTION_WIDTH)
  ) u_accum (
    .clk    (clk),
    .reset  (reset),
    .valid  (vld_q),
    .first  (vidx_q == '0),
    .data   (bus.rd_data),
    .index  (vidx_q),
    .max_nxt(acc_max),
    .idx_nxt(acc_idx)
  );

  assign bus.busy        = (st_q != ST_IDLE);
  assign bus.rd_en       = (st_q == ST_SCAN);
  assign bus.rd_addr     = ADDR_WIDTH'(mk_rd_addr(32'(state_q), 32'(cnt_q), ACTION_WIDTH));
  assign bus.done        = (st_q == ST_DONE);
  assign bus.max_q       = max_q_q;
  assign bus.best_action = best_q;
endmodule

// File: tb/tb_q_argmax_scan.sv
// Bench for q_argmax_scan: RAM model with 1-cycle read latency, argmax
// reference computed directly from the RAM contents.
module tb_q_argmax_scan;
  import q_argmax_scan_pkg::*;

  logic clk;
  logic reset;
  int   nvec;
  int   nerr;

  q_val_t mem [0:1023];

  q_argmax_scan_if #(.DATA_LENGTH(32), .ACTION_WIDTH(2), .STATE_WIDTH(8)) bus ();

  q_argmax_scan #(
    .DATA_LENGTH(32), .NUM_ACTIONS(4), .ACTION_WIDTH(2), .STATE_WIDTH(8)
  ) dut (
    .clk  (clk),
    .reset(reset),
    .bus  (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (bus.rd_en) bus.rd_data <= mem[bus.rd_addr];
  end

  task automatic load(input logic [7:0] s, input q_val_t a0, input q_val_t a1,
                      input q_val_t a2, input q_val_t a3);
    mem[{s, 2'd0}] = a0;
    mem[{s, 2'd1}] = a1;
    mem[{s, 2'd2}] = a2;
    mem[{s, 2'd3}] = a3;
  endtask

  // Reference: largest value, first occurrence wins.
  task automatic model(input logic [7:0] s, output q_val_t m, output logic [1:0] a);
    q_val_t v;
    m = mem[{s, 2'd0}];
    a = 2'd0;
    for (int k = 1; k < 4; k++) begin
      v = mem[{s, 2'(k)}];
      if (v > m) begin
        m = v;
        a = 2'(k);
      end
    end
  endtask

  function automatic q_val_t rv();
    case ($urandom_range(0, 4))
      0:       rv = q_val_t'(32'h8000_0000);
      1:       rv = q_val_t'(32'h7fff_ffff);
      2:       rv = q_val_t'($urandom_range(0, 2)) - 1;
      default: rv = q_val_t'($urandom);
    endcase
  endfunction

  // Issues one start and observes until done (bounded). Only observes; the
  // callers compare. lat = cycle of done counted from acceptance, -1 on timeout.
  task automatic do_scan(input logic [7:0] s, output int lat, output bit addr_ok,
                         output bit held, output q_val_t mq, output logic [1:0] ba);
    q_val_t     pre_q;
    logic [1:0] pre_a;
    int         k;
    pre_q = bus.max_q;
    pre_a = bus.best_action;
    @(negedge clk);
    bus.start    = 1'b1;
    bus.state_in = s;
    @(negedge clk);
    bus.start = 1'b0;
    lat = -1; addr_ok = 1'b1; held = 1'b1; k = 0;
    mq = '0; ba = '0;
    for (int c = 1; c <= 20; c++) begin
      if (bus.rd_en) begin
        if (c != k + 1 || bus.rd_addr !== {s, 2'(k)}) addr_ok = 1'b0;
        k++;
      end
      if (bus.done) begin
        lat = c;
        mq  = bus.max_q;
        ba  = bus.best_action;
        break;
      end
      if (bus.max_q !== pre_q || bus.best_action !== pre_a) held = 1'b0;
      @(negedge clk);
    end
    if (k != 4) addr_ok = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    repeat (3) @(negedge clk);
    nvec++; if (bus.busy !== 1'b0) begin nerr++; $display("FAIL reset_busy: got %b want 0", bus.busy); end
    nvec++; if (bus.rd_en !== 1'b0) begin nerr++; $display("FAIL reset_rd_en: got %b want 0", bus.rd_en); end
    nvec++; if (bus.done !== 1'b0) begin nerr++; $display("FAIL reset_done: got %b want 0", bus.done); end
    nvec++; if (bus.rd_addr !== 10'd0) begin nerr++; $display("FAIL reset_rd_addr: got %h want 0", bus.rd_addr); end
    nvec++; if (bus.max_q !== 32'sd0 || bus.best_action !== 2'd0) begin
      nerr++; $display("FAIL reset_outputs: got %0d/%0d want 0/0", bus.max_q, bus.best_action); end
    reset = 1'b0;
  endtask

  task automatic test_basic();
    int lat; bit aok, held; q_val_t mq; logic [1:0] ba;
    load(8'd5, 10, -3, 42, 7);
    do_scan(8'd5, lat, aok, held, mq, ba);
    nvec++; if (lat != 6) begin nerr++; $display("FAIL basic_latency: got %0d want 6", lat); end
    nvec++; if (!aok) begin nerr++; $display("FAIL basic_addr_seq: got bad want 0x14..0x17"); end
    nvec++; if (mq !== 42 || ba !== 2'd2) begin nerr++; $display("FAIL basic_result: got %0d/%0d want 42/2", mq, ba); end
    @(negedge clk);
    nvec++; if (bus.done !== 1'b0 || bus.busy !== 1'b0) begin
      nerr++; $display("FAIL basic_done_pulse: got done=%b busy=%b want 0/0", bus.done, bus.busy); end
  endtask

  task automatic test_ties();
    int lat; bit aok, held; q_val_t mq; logic [1:0] ba;
    load(8'd3, 9, 9, 9, 9);
    do_scan(8'd3, lat, aok, held, mq, ba);
    nvec++; if (mq !== 9 || ba !== 2'd0) begin nerr++; $display("FAIL ties_all: got %0d/%0d want 9/0", mq, ba); end
    load(8'd4, 1, 9, 9, 3);
    do_scan(8'd4, lat, aok, held, mq, ba);
    nvec++; if (mq !== 9 || ba !== 2'd1) begin nerr++; $display("FAIL ties_mid: got %0d/%0d want 9/1", mq, ba); end
  endtask

  task automatic test_negative();
    int lat; bit aok, held; q_val_t mq; logic [1:0] ba;
    q_val_t mn;
    mn = q_val_t'(32'h8000_0000);
    load(8'd9, -5, -2, -8, mn);
    do_scan(8'd9, lat, aok, held, mq, ba);
    nvec++; if (mq !== -2 || ba !== 2'd1) begin nerr++; $display("FAIL neg_mix: got %0d/%0d want -2/1", mq, ba); end
    load(8'd10, mn, mn, mn, mn);
    do_scan(8'd10, lat, aok, held, mq, ba);
    nvec++; if (mq !== mn || ba !== 2'd0) begin nerr++; $display("FAIL neg_all_min: got %0d/%0d want %0d/0", mq, ba, mn); end
  endtask

  task automatic test_busy_ignore();
    q_val_t em; logic [1:0] ea;
    int dones, lat; q_val_t mq; logic [1:0] ba;
    load(8'd20, rv(), rv(), rv(), rv());
    load(8'd21, 100, 200, 300, 400);
    model(8'd20, em, ea);
    dones = 0; lat = -1; mq = '0; ba = '0;
    @(negedge clk);
    bus.start = 1'b1; bus.state_in = 8'd20;
    for (int c = 1; c <= 14; c++) begin
      @(negedge clk);
      if (bus.done) begin dones++; lat = c; mq = bus.max_q; ba = bus.best_action; end
      // Keep hammering start and a different state through DRAIN
      if (c <= 4) begin bus.start = 1'b1; bus.state_in = 8'd21; end
      else        bus.start = 1'b0;
    end
    nvec++; if (dones != 1) begin nerr++; $display("FAIL busy_done_count: got %0d want 1", dones); end
    nvec++; if (lat != 6) begin nerr++; $display("FAIL busy_latency: got %0d want 6", lat); end
    nvec++; if (mq !== em || ba !== ea) begin nerr++; $display("FAIL busy_captured_state: got %0d/%0d want %0d/%0d", mq, ba, em, ea); end
  endtask

  task automatic test_reset_mid();
    int lat, dones; bit aok, held; q_val_t mq, em; logic [1:0] ba, ea;
    load(8'd30, rv(), rv(), 55, rv());
    model(8'd30, em, ea);
    @(negedge clk);
    bus.start = 1'b1; bus.state_in = 8'd30;
    @(negedge clk);
    bus.start = 1'b0;
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    nvec++; if (bus.busy !== 1'b0 || bus.rd_en !== 1'b0 || bus.done !== 1'b0) begin
      nerr++; $display("FAIL rstmid_ctrl: got busy=%b rd_en=%b done=%b want 0/0/0", bus.busy, bus.rd_en, bus.done); end
    nvec++; if (bus.max_q !== 32'sd0 || bus.best_action !== 2'd0 || bus.rd_addr !== 10'd0) begin
      nerr++; $display("FAIL rstmid_outputs: got %0d/%0d/%h want 0/0/0", bus.max_q, bus.best_action, bus.rd_addr); end
    reset = 1'b0;
    dones = 0;
    repeat (8) begin @(negedge clk); if (bus.done) dones++; end
    nvec++; if (dones != 0) begin nerr++; $display("FAIL rstmid_no_done: got %0d want 0", dones); end
    do_scan(8'd30, lat, aok, held, mq, ba);
    nvec++; if (lat != 6 || !aok || mq !== em || ba !== ea) begin
      nerr++; $display("FAIL rstmid_rescan: got lat=%0d addr=%b %0d/%0d want 6/1 %0d/%0d", lat, aok, mq, ba, em, ea); end
  endtask

  task automatic test_back_to_back();
    int lat; bit aok, held; q_val_t mq, em; logic [1:0] ba, ea;
    load(8'd40, 1, 2, 3, 4);
    load(8'd41, 70, -1, 5, 6);
    model(8'd40, em, ea);
    do_scan(8'd40, lat, aok, held, mq, ba);
    nvec++; if (lat != 6 || mq !== em || ba !== ea) begin
      nerr++; $display("FAIL b2b_first: got lat=%0d %0d/%0d want 6 %0d/%0d", lat, mq, ba, em, ea); end
    model(8'd41, em, ea);
    do_scan(8'd41, lat, aok, held, mq, ba);
    nvec++; if (lat != 6) begin nerr++; $display("FAIL b2b_latency: got %0d want 6", lat); end
    nvec++; if (!held) begin nerr++; $display("FAIL b2b_hold: got early update want hold until done"); end
    nvec++; if (mq !== em || ba !== ea) begin nerr++; $display("FAIL b2b_second: got %0d/%0d want %0d/%0d", mq, ba, em, ea); end
  endtask

  task automatic test_random();
    int lat; bit aok, held; q_val_t mq, em; logic [1:0] ba, ea;
    logic [7:0] s;
    for (int i = 0; i < 24; i++) begin
      s = 8'($urandom);
      load(s, rv(), rv(), rv(), rv());
      model(s, em, ea);
      do_scan(s, lat, aok, held, mq, ba);
      nvec++; if (lat != 6 || !aok || !held || mq !== em || ba !== ea) begin
        nerr++;
        $display("FAIL random_%0d: s=%0d got lat=%0d addr=%b held=%b %0d/%0d want 6/1/1 %0d/%0d",
                 i, s, lat, aok, held, mq, ba, em, ea);
      end
    end
  endtask

  initial begin
    nvec = 0; nerr = 0;
    reset = 1'b1;
    bus.start = 1'b0;
    bus.state_in = '0;
    for (int i = 0; i < 1024; i++) mem[i] = '0;
    test_reset();
    test_basic();
    test_ties();
    test_negative();
    test_busy_ignore();
    test_reset_mid();
    test_back_to_back();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end
endmodule
